audio_in_pitch_tracker: RTL and testbench

//  Receive side of the Audio_Controller sample stream: pops ADC samples via the

---
 rtl/audio_in_pitch_tracker.sv | 132 +++++++++++++
 tb/tb_audio_in_pitch_tracker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_in_pitch_tracker.sv
// Pops L/R samples from the Audio_Controller, mixes them to mono, and measures the
// zero-crossing period and windowed peak level. Define AUDIO_IN_MONO_LEFT_EN to use the left channel only.
module audio_in_pitch_tracker #(
  parameter logic signed [31:0] HYST       = 32'sd4000000,
  parameter int                 WINDOW     = 1024,
  parameter logic [15:0]        MAX_PERIOD = 16'd4800
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        audio_in_available,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic [31:0] sample_out,
  output logic        sample_valid,
  output logic [15:0] period_samples,
  output logic        period_valid,
  output logic [30:0] peak_level,
  output logic        level_valid
);

  localparam int                WIN_W    = $clog2(WINDOW);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, PROCESS} state_t;

  state_t             state_reg, state_next;
  logic signed [31:0] left_reg, right_reg;
  logic signed [31:0] mono, mono_neg;
  logic [30:0]        mag, pk_max, pk_reg;
  logic [15:0]        cnt_reg, cnt_inc;
  logic [WIN_W-1:0]   win_reg;
  logic               armed_reg, seen_reg;
  logic               crossing, win_end;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // The pop strobe is decoded from the state so an async reset removes it at once.
  always_comb begin
    state_next    = state_reg;
    read_audio_in = 1'b0;
    case (state_reg)
      IDLE:    if (audio_in_available) state_next = CAPTURE;
      CAPTURE: begin
        read_audio_in = 1'b1;
        state_next    = PROCESS;
      end
      PROCESS: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
`ifdef AUDIO_IN_MONO_LEFT_EN
    mono = left_reg;
`else
    mono = (left_reg >>> 1) + (right_reg >>> 1);
`endif
    mono_neg = -mono;
    // Negating the most negative value stays negative: that case saturates.
    if (!mono[31])         mag = mono[30:0];
    else if (mono_neg[31]) mag = 31'h7FFF_FFFF;
    else                   mag = mono_neg[30:0];
    pk_max   = (mag > pk_reg) ? mag : pk_reg;
    cnt_inc  = cnt_reg + 16'd1;
    crossing = armed_reg && (mono >= HYST);
    win_end  = (win_reg == WIN_LAST);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      left_reg       <= '0;
      right_reg      <= '0;
      armed_reg      <= 1'b0;
      seen_reg       <= 1'b0;
      cnt_reg        <= '0;
      win_reg        <= '0;
      pk_reg         <= '0;
      sample_out     <= '0;
      sample_valid   <= 1'b0;
      period_samples <= '0;
      period_valid   <= 1'b0;
      peak_level     <= '0;
      level_valid    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      period_valid <= 1'b0;
      level_valid  <= 1'b0;
      if (state_reg == CAPTURE) begin
        left_reg  <= left_channel_audio_in;
        right_reg <= right_channel_audio_in;
      end
      if (state_reg == PROCESS) begin
        sample_out   <= mono;
        sample_valid <= 1'b1;
        if (crossing) begin
          armed_reg <= 1'b0;
          if (seen_reg) begin
            period_samples <= cnt_inc;
            period_valid   <= 1'b1;
          end
          seen_reg <= 1'b1;
          cnt_reg  <= '0;
        end else begin
          if (mono < -HYST) armed_reg <= 1'b1;
          // Too long without a crossing: report silence and restart the search.
          if (cnt_inc == MAX_PERIOD) begin
            period_samples <= '0;
            period_valid   <= 1'b1;
            cnt_reg        <= '0;
            seen_reg       <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        if (win_end) begin
          peak_level  <= pk_max;
          level_valid <= 1'b1;
          pk_reg      <= '0;
          win_reg     <= '0;
        end else begin
          pk_reg  <= pk_max;
          win_reg <= win_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_in_pitch_tracker.sv
// Randomized bench for audio_in_pitch_tracker; a sample-stream reference model predicts
// every output. Honours AUDIO_IN_MONO_LEFT_EN the same way as the design.
module tb_audio_in_pitch_tracker;

  localparam int                 TB_WINDOW  = 4;
  localparam logic signed [31:0] TB_HYST    = 32'sd4000000;
  localparam logic [15:0]        TB_MAX_PER = 16'd4800;
  localparam longint             HYST_L     = 4000000;
  localparam longint             MAXP_L     = 4800;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        audio_in_available = 1'b0;
  logic [31:0] left_channel_audio_in = '0;
  logic [31:0] right_channel_audio_in = '0;
  logic        read_audio_in;
  logic [31:0] sample_out;
  logic        sample_valid;
  logic [15:0] period_samples;
  logic        period_valid;
  logic [30:0] peak_level;
  logic        level_valid;

  audio_in_pitch_tracker #(
    .HYST(TB_HYST), .WINDOW(TB_WINDOW), .MAX_PERIOD(TB_MAX_PER)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .audio_in_available(audio_in_available),
    .left_channel_audio_in(left_channel_audio_in),
    .right_channel_audio_in(right_channel_audio_in),
    .read_audio_in(read_audio_in),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .period_samples(period_samples),
    .period_valid(period_valid),
    .peak_level(peak_level),
    .level_valid(level_valid)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  // Reference model: indices into the sample stream since the last reset.
  longint n_idx, ref_idx;
  bit     m_armed, m_seen;
  longint win_q[$];
  longint exp_sample, exp_period, exp_level;
  bit     exp_pv, exp_lv;

  // Last observed DUT pulses, for the directed checks.
  bit     dut_pv, dut_lv;
  int     txn = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint half_floor(input longint v);
    return (v - (v & 64'sd1)) / 2;
  endfunction

  task automatic model_reset();
    n_idx = 0; ref_idx = -1; m_armed = 0; m_seen = 0;
    win_q.delete();
    exp_sample = 0; exp_period = 0; exp_level = 0; exp_pv = 0; exp_lv = 0;
  endtask

  task automatic model_step(input logic [31:0] l, input logic [31:0] r);
    longint lv, rv, m, a, mx;
    lv = longint'($signed(l));
    rv = longint'($signed(r));
`ifdef AUDIO_IN_MONO_LEFT_EN
    m = lv;
    if (rv == 0) m = lv;
`else
    m = half_floor(lv) + half_floor(rv);
`endif
    a = (m < 0) ? -m : m;
    if (a > 64'sh7FFF_FFFF) a = 64'sh7FFF_FFFF;
    exp_sample = m; exp_pv = 0; exp_lv = 0;
    if (m_armed && m >= HYST_L) begin
      m_armed = 0;
      if (m_seen) begin
        exp_period = n_idx - ref_idx;
        exp_pv = 1;
      end
      m_seen = 1;
      ref_idx = n_idx;
    end else begin
      if (m < -HYST_L) m_armed = 1;
      if (n_idx - ref_idx == MAXP_L) begin
        exp_period = 0; exp_pv = 1; ref_idx = n_idx; m_seen = 0;
      end
    end
    win_q.push_back(a);
    if (win_q.size() == TB_WINDOW) begin
      mx = 0;
      foreach (win_q[i]) if (win_q[i] > mx) mx = win_q[i];
      exp_level = mx; exp_lv = 1;
      win_q.delete();
    end
    n_idx++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    audio_in_available = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();
  endtask

  // One transaction: offer a sample, wait for its pop, then compare the result pulses.
  task automatic push(input logic [31:0] l, input logic [31:0] r);
    bit got;
    @(negedge CLOCK_50);
    audio_in_available = 1'b1;
    left_channel_audio_in = l;
    right_channel_audio_in = r;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CLOCK_50);
      if (read_audio_in) got = 1;
    end
    check_val("pop_seen", longint'(got), 1);
    audio_in_available = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    model_step(l, r);
    dut_pv = period_valid;
    dut_lv = level_valid;
    check_val("sample_valid", longint'(sample_valid), 1);
    check_val("sample_out", longint'($signed(sample_out)), exp_sample);
    check_val("period_valid", longint'(period_valid), longint'(exp_pv));
    check_val("period_samples", longint'(period_samples), exp_period);
    check_val("level_valid", longint'(level_valid), longint'(exp_lv));
    check_val("peak_level", longint'(peak_level), exp_level);
    $display("txn %0d L=%h R=%h out=%h pv=%0d per=%0d lv=%0d pk=%h",
             txn, l, r, sample_out, period_valid, period_samples, level_valid, peak_level);
    txn++;
    @(negedge CLOCK_50);
    check_val("pulse_width", longint'({sample_valid, period_valid, level_valid}), 0);
  endtask

  initial begin
    int reads, last, pcount, pidx;
    bit got;
    logic [31:0] v, w;
    longint sv;

    model_reset();
    repeat (3) @(negedge CLOCK_50);
    check_val("rst_read", longint'(read_audio_in), 0);
    check_val("rst_outs", longint'({sample_out, period_samples, peak_level,
                                    sample_valid, period_valid, level_valid} != 0), 0);
    reset = 1'b0;

    // Continuous availability: one pop every third cycle.
    @(negedge CLOCK_50);
    audio_in_available = 1'b1;
    reads = 0; last = -100;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLOCK_50);
      if (read_audio_in) begin
        if (reads > 0) check_val("pop_spacing", longint'(c - last), 3);
        reads++;
        last = c;
      end
    end
    audio_in_available = 1'b0;
    check_val("pops_in_30", longint'(reads), 10);
    do_reset();

    reads = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLOCK_50);
      if (read_audio_in) reads++;
    end
    check_val("no_avail_no_pop", longint'(reads), 0);

    // Square wave, 110-sample period.
    pcount = 0;
    for (int k = 0; k < 450; k++) begin
      v = ((k % 110) < 55) ? 32'h1000_0000 : 32'hF000_0000;
      push(v, v);
      if (dut_pv) begin
        pcount++;
        check_val("square_period", longint'(period_samples), 110);
      end
    end
    check_val("square_pulses", longint'(pcount), 3);

    // Reset landing while the pop strobe is high.
    @(negedge CLOCK_50);
    audio_in_available = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge CLOCK_50);
      if (read_audio_in) got = 1;
    end
    check_val("cap_seen", longint'(got), 1);
    #2 reset = 1'b1;
    #1;
    check_val("rst_cap_read", longint'(read_audio_in), 0);
    check_val("rst_cap_outs", longint'({sample_out, period_samples, peak_level,
                                        sample_valid, period_valid, level_valid} != 0), 0);
    audio_in_available = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    model_reset();

    // Most negative left sample over one window.
    for (int k = 0; k < TB_WINDOW; k++) push(32'h8000_0000, 32'h0);
`ifdef AUDIO_IN_MONO_LEFT_EN
    check_val("peak_minleft", longint'(peak_level), 64'h7FFF_FFFF);
`else
    check_val("peak_minleft", longint'(peak_level), 64'h4000_0000);
`endif
    for (int k = 0; k < TB_WINDOW; k++) push(32'h8000_0000, 32'h8000_0000);
    check_val("peak_minboth", longint'(peak_level), 64'h7FFF_FFFF);

    // Period end on the last sample of a window.
    do_reset();
    push(32'hF000_0000, 32'hF000_0000);
    push(32'h1000_0000, 32'h1000_0000);
    push(32'hF000_0000, 32'hF000_0000);
    push(32'h1000_0000, 32'h1000_0000);
    check_val("coincident", longint'({dut_pv, dut_lv}), 3);
    check_val("coinc_period", longint'(period_samples), 2);

    // Mixed random traffic.
    do_reset();
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 3))
        0: begin v = $urandom; w = $urandom; end
        1: begin
          v = $urandom_range(0, 1) ? 32'h2000_0000 : 32'hE000_0000;
          w = v ^ {8'h0, 24'($urandom)};
        end
        2: begin
          sv = longint'($urandom_range(0, 2 * 3999999)) - 3999999;
          v = 32'(sv); w = v;
        end
        default: begin
          v = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
          w = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
      endcase
      push(v, w);
    end

    // Silence inside the hysteresis band until the timeout.
    do_reset();
    pcount = 0; pidx = -1;
    for (int k = 0; k < 4800; k++) begin
      sv = longint'($urandom_range(0, 2 * 3999999)) - 3999999;
      v = 32'(sv);
      push(v, v);
      if (dut_pv) begin
        pcount++;
        pidx = k;
        check_val("silence_period", longint'(period_samples), 0);
      end
    end
    check_val("silence_pulses", longint'(pcount), 1);
    check_val("silence_index", longint'(pidx), 4799);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
